// File: rtl/yapp_pkg.sv
// Shared YAPP definitions: byte width, header field positions and the
// input-arbiter state encoding.
package yapp_pkg;

  localparam int YAPP_DATA_WIDTH = 8;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [YAPP_DATA_WIDTH-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/yapp_rr_arbiter.sv
// Combinational NUM_SRC-way round-robin pick: first requester at or after
// ptr_i, wrapping, returned both one-hot and as an index.
module yapp_rr_arbiter #(
  parameter  int NUM_SRC = 3,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [NUM_SRC-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [IDX_W:0]       off;
  logic [IDX_W:0]       sum;

  // Rotating the doubled vector puts the highest-priority requester at bit 0.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_i +: NUM_SRC];
  assign any_o   = |req_i;

  always_comb begin
    off = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) off = (IDX_W+1)'(i);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= (IDX_W+1)'(NUM_SRC)) sum = sum - (IDX_W+1)'(NUM_SRC);
  end

  assign idx_o = sum[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pick
      assign pick_o[gi] = any_o && (idx_o == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/yapp_in_arb.sv
// Packet-granular round-robin arbiter sharing the YAPP router input port
// between NUM_SRC sources; drops oversize packets and inserts the idle gap.
module yapp_in_arb
  import yapp_pkg::*;
#(
  parameter  int NUM_SRC    = 3,
  parameter  int DATA_WIDTH = YAPP_DATA_WIDTH,
  localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arb_en,
  input  logic [HDR_LEN_W-1:0]          max_pkt_size,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_vld,
  output logic [NUM_SRC-1:0]            src_suspend,
  output logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_data_vld,
  input  logic                          in_suspend,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          drop_err,
  output logic                          proto_err
);

  arb_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [6:0]           remaining_q, remaining_d;
  logic                 drop_err_q, drop_err_d;
  logic                 proto_err_q, proto_err_d;

  logic                 pick_any;
  logic [NUM_SRC-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_WIDTH-1:0] src_byte [NUM_SRC];
  logic [DATA_WIDTH-1:0] sel_byte, pick_byte;
  logic                 sel_vld;
  logic [HDR_LEN_W-1:0] pick_len;

  yapp_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i  (src_vld),
    .ptr_i  (rr_ptr_q),
    .any_o  (pick_any),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_byte
      assign src_byte[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // AND-OR muxes keyed by one-hot vectors: the owner's stream and the
  // candidate header seen while idle.
  always_comb begin
    sel_byte  = '0;
    sel_vld   = 1'b0;
    pick_byte = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_byte = sel_byte | src_byte[i];
        sel_vld  = sel_vld | src_vld[i];
      end
      if (pick[i]) pick_byte = pick_byte | src_byte[i];
    end
  end

  assign pick_len = hdr_len(pick_byte);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    drop_err_d  = 1'b0;
    proto_err_d = 1'b0;
    in_data     = '0;
    in_data_vld = 1'b0;
    src_suspend = '1;

    case (state_q)
      IDLE: begin
        if (arb_en && pick_any) begin
          grant_d     = pick;
          rr_ptr_d    = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
          remaining_d = {1'b0, pick_len} + 7'd2;
          if (pick_len > max_pkt_size) begin
            state_d    = DROP;
            drop_err_d = 1'b1;
          end else begin
            state_d = XFER;
          end
        end
      end

      XFER: begin
        in_data     = sel_byte;
        in_data_vld = sel_vld;
        src_suspend = ~grant_q | {NUM_SRC{in_suspend}};
        if (!sel_vld) begin
          proto_err_d = 1'b1;
          state_d     = GAP;
          grant_d     = '0;
          remaining_d = '0;
        end else if (!in_suspend) begin
          remaining_d = remaining_q - 7'd1;
          if (remaining_q == 7'd1) begin
            state_d = GAP;
            grant_d = '0;
          end
        end
      end

      DROP: begin
        // Discarded bytes are pulled regardless of router back-pressure.
        src_suspend = ~grant_q;
        if (!sel_vld) begin
          proto_err_d = 1'b1;
          state_d     = GAP;
          grant_d     = '0;
          remaining_d = '0;
        end else begin
          remaining_d = remaining_q - 7'd1;
          if (remaining_q == 7'd1) begin
            state_d = GAP;
            grant_d = '0;
          end
        end
      end

      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      drop_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      drop_err_q  <= drop_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign grant     = grant_q;
  assign drop_err  = drop_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_yapp_in_arb.sv
// Directed bench for yapp_in_arb: packet-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_yapp_in_arb;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           arb_en = 1'b1;
  logic [5:0]     max_pkt_size = 6'd63;
  logic [N*8-1:0] src_data = '0;
  logic [N-1:0]   src_vld = '0;
  logic [N-1:0]   src_suspend;
  logic [7:0]     in_data;
  logic           in_data_vld;
  logic           in_suspend = 1'b0;
  logic [N-1:0]   grant;
  logic           drop_err;
  logic           proto_err;

  yapp_in_arb #(.NUM_SRC(N), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_en       (arb_en),
    .max_pkt_size (max_pkt_size),
    .src_data     (src_data),
    .src_vld      (src_vld),
    .src_suspend  (src_suspend),
    .in_data      (in_data),
    .in_data_vld  (in_data_vld),
    .in_suspend   (in_suspend),
    .grant        (grant),
    .drop_err     (drop_err),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  // Source byte streams; the front byte is presented until accepted.
  logic [7:0] srcq [N][$];
  logic [N-1:0] take = '0;

  int checks = 0;
  int passes = 0;

  // Observations for the literal checks.
  logic [7:0] obs[$];
  logic [7:0] grants[$];
  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];
  int n_derr = 0, n_perr = 0, n_take1 = 0;
  int cyc = 0, first_vld = -1, last_vld = -1;
  logic [N-1:0] prev_grant = '0;

  // Reference model state: packet owner, bytes still owed, discard flag,
  // pending quiet cycle, rotating priority and pending error pulses.
  int m_owner = -1, m_left = 0, m_rr = 0;
  bit m_drop = 0, m_gap = 0, m_derr = 0, m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk_seq(input string name);
    chk({name, "_len"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk(name, act_q[i], exp_q[i]);
  endtask

  function automatic logic [7:0] byte_of(input int s);
    return src_data[s*8 +: 8];
  endfunction

  function automatic logic [7:0] oh_idx(input logic [N-1:0] v);
    logic [7:0] r = 8'hFF;
    for (int i = 0; i < N; i++) if (v[i]) r = 8'(i);
    return r;
  endfunction

  task automatic drive_srcs();
    for (int s = 0; s < N; s++) begin
      if (srcq[s].size() > 0) begin
        src_vld[s] = 1'b1;
        src_data[s*8 +: 8] = srcq[s][0];
      end else begin
        src_vld[s] = 1'b0;
        src_data[s*8 +: 8] = 8'h00;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int s = 0; s < N; s++)
      if (take[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
    drive_srcs();
  end

  // Compare process: expectations from the model, then model advance.
  always @(negedge clk) begin : cmp
    logic [7:0]   e_data;
    logic         e_vld;
    logic [N-1:0] e_susp, e_grant;
    logic [7:0]   hdr;
    int           pk, len;

    if (reset) begin
      m_owner = -1; m_left = 0; m_rr = 0;
      m_drop = 0; m_gap = 0; m_derr = 0; m_perr = 0;
    end

    e_data = 8'h00; e_vld = 1'b0; e_susp = '1; e_grant = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (m_drop) e_susp[m_owner] = 1'b0;
      else begin
        e_data = byte_of(m_owner);
        e_vld  = src_vld[m_owner];
        e_susp[m_owner] = in_suspend;
      end
    end
    chk("in_data", in_data, e_data);
    chk("in_data_vld", in_data_vld, e_vld);
    chk("src_suspend", src_suspend, e_susp);
    chk("grant", grant, e_grant);
    chk("drop_err", drop_err, m_derr);
    chk("proto_err", proto_err, m_perr);

    if (in_data_vld && !in_suspend) obs.push_back(in_data);
    if (drop_err) n_derr++;
    if (proto_err) n_perr++;
    if (grant != 0 && prev_grant == 0) grants.push_back(oh_idx(grant));
    prev_grant = grant;
    if (in_data_vld) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    cyc++;

    take = src_vld & ~src_suspend;
    if (take[1]) n_take1++;

    if (!reset) begin
      m_derr = 0; m_perr = 0;
      if (m_gap) m_gap = 0;
      else if (m_owner < 0) begin
        if (arb_en && src_vld != 0) begin
          pk = -1;
          for (int k = 0; k < N; k++)
            if (pk < 0 && src_vld[(m_rr + k) % N]) pk = (m_rr + k) % N;
          hdr = byte_of(pk);
          len = int'(hdr[7:2]);
          m_owner = pk;
          m_left = len + 2;
          m_rr = (pk + 1) % N;
          if (len > int'(max_pkt_size)) begin
            m_drop = 1; m_derr = 1;
          end
        end
      end else if (!src_vld[m_owner]) begin
        m_perr = 1; m_owner = -1; m_drop = 0; m_gap = 1;
      end else if (m_drop || !in_suspend) begin
        m_left--;
        if (m_left == 0) begin
          m_owner = -1; m_drop = 0; m_gap = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_stats();
    obs.delete(); grants.delete();
    n_derr = 0; n_perr = 0; n_take1 = 0;
    first_vld = -1; last_vld = -1;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size()) != 0 && t < 300) begin
      tick(); t++;
    end
    chk("quiet_timeout", t < 300, 1);
    repeat (4) tick();
  endtask

  task automatic wait_byte(input logic [7:0] b);
    int t = 0;
    while (!(in_data_vld && in_data == b) && t < 100) begin
      tick(); t++;
    end
    chk("wait_byte_timeout", t < 100, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_srcs();
    repeat (3) tick();
    chk("rst_grant", grant, 3'b000);
    chk("rst_susp", src_suspend, 3'b111);
    reset = 1'b0;

    // Single packet from source 0.
    clear_stats();
    srcq[0] = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    drive_srcs();
    wait_quiet();
    act_q = obs; exp_q = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C}; chk_seq("t1_bytes");
    act_q = grants; exp_q = {8'd0}; chk_seq("t1_grants");

    // Round robin, all sources busy with len-1 packets.
    pulse_reset();
    clear_stats();
    srcq[0] = {8'h04, 8'hA0, 8'hA4, 8'h04, 8'hA1, 8'hA5};
    srcq[1] = {8'h05, 8'hB0, 8'hB5, 8'h05, 8'hB1, 8'hB6};
    srcq[2] = {8'h06, 8'hC0, 8'hC6, 8'h06, 8'hC1, 8'hC7};
    drive_srcs();
    wait_quiet();
    act_q = grants; exp_q = {8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2}; chk_seq("t2_grants");
    chk("t2_window", last_vld - first_vld + 1, 28);
    chk("t2_nbytes", obs.size(), 18);

    // Back-pressure for 4 cycles mid-payload.
    clear_stats();
    srcq[0] = {8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10};
    drive_srcs();
    wait_byte(8'h02);
    in_suspend = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_data", in_data, 8'h02);
      chk("hold_susp", src_suspend[0], 1'b1);
      tick();
    end
    in_suspend = 1'b0;
    wait_quiet();
    act_q = obs; exp_q = {8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10}; chk_seq("t3_bytes");

    // Oversize packet on source 1 dropped, source 2 served next.
    clear_stats();
    max_pkt_size = 6'd4;
    srcq[1] = {8'h19, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'h19};
    srcq[2] = {8'h06, 8'hC1, 8'h06};
    drive_srcs();
    wait_quiet();
    chk("t4_drop_err", n_derr, 1);
    chk("t4_consumed", n_take1, 8);
    act_q = obs; exp_q = {8'h06, 8'hC1, 8'h06}; chk_seq("t4_bytes");
    act_q = grants; exp_q = {8'd1, 8'd2}; chk_seq("t4_grants");
    max_pkt_size = 6'd63;

    // Source 0 stops after 2 of 5 bytes.
    clear_stats();
    srcq[0] = {8'h0C, 8'hE1};
    drive_srcs();
    wait_quiet();
    chk("t5_proto_err", n_perr, 1);
    chk("t5_drop_err", n_derr, 0);
    act_q = obs; exp_q = {8'h0C, 8'hE1}; chk_seq("t5_bytes");

    // Reset during payload, then priority restarts at source 0.
    clear_stats();
    srcq[1] = {8'h11, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h11};
    drive_srcs();
    wait_byte(8'hF2);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", in_data_vld, 1'b0);
    chk("mid_rst_data", in_data, 8'h00);
    chk("mid_rst_grant", grant, 3'b000);
    chk("mid_rst_susp", src_suspend, 3'b111);
    tick();
    for (int s = 0; s < N; s++) srcq[s].delete();
    drive_srcs();
    tick();
    reset = 1'b0;
    clear_stats();
    srcq[0] = {8'h04, 8'hA1, 8'h04};
    srcq[2] = {8'h06, 8'hC2, 8'h06};
    drive_srcs();
    wait_quiet();
    act_q = grants; exp_q = {8'd0, 8'd2}; chk_seq("t6_grants");
    act_q = obs; exp_q = {8'h04, 8'hA1, 8'h04, 8'h06, 8'hC2, 8'h06}; chk_seq("t6_bytes");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
